rect_sum_reader: RTL and testbench

RECT_SUM_READER -- requirements
Module: rect_sum_reader

---
 rtl/facedet_pkg.sv | 36 +++
 rtl/rect_addr_gen.sv | 57 +++++
 rtl/rect_sum_reader.sv | 177 +++++++++++++++++
 tb/tb_rect_sum_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/facedet_pkg.sv
// Shared widths, FSM/corner enums and the rectangle payload for the integral-image readers.
package facedet_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned TILE_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_RESP
    } state_e;

    // Fetch order is the enum order: D first, A last.
    typedef enum logic [1:0] {
        CRN_D,
        CRN_B,
        CRN_C,
        CRN_A
    } corner_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } rect_t;

    // B and C are subtracted, D and A are added.
    function automatic logic corner_negative(input corner_e c);
        return (c == CRN_B) || (c == CRN_C);
    endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// Maps one rectangle corner to its row-major tile address; flags corners that lie outside the tile.
module rect_addr_gen
    import facedet_pkg::*;
#(
    parameter int unsigned AW = ADDR_W
) (
    input  corner_e             corner_i,
    input  rect_t               rect_i,
    input  logic [TILE_W-1:0]   tile_size_i,
    output logic [AW-1:0]       addr_c_o,
    output logic                skip_c_o
);

    localparam int unsigned EW = COORD_W + 1;

    logic [EW-1:0] far_row;
    logic [EW-1:0] far_col;
    logic [EW-1:0] near_row;
    logic [EW-1:0] near_col;
    logic [EW-1:0] row;
    logic [EW-1:0] col;

    assign far_row  = EW'(rect_i.y) + EW'(rect_i.h) - EW'(1);
    assign far_col  = EW'(rect_i.x) + EW'(rect_i.w) - EW'(1);
    assign near_row = EW'(rect_i.y) - EW'(1);
    assign near_col = EW'(rect_i.x) - EW'(1);

    // Near row/column wrap when y or x is 0; such corners are skipped, so the address is don't-care.
    always_comb begin
        row      = far_row;
        col      = far_col;
        skip_c_o = 1'b0;
        case (corner_i)
            CRN_D: begin
                row = far_row;
                col = far_col;
            end
            CRN_B: begin
                row      = near_row;
                col      = far_col;
                skip_c_o = (rect_i.y == '0);
            end
            CRN_C: begin
                row      = far_row;
                col      = near_col;
                skip_c_o = (rect_i.x == '0);
            end
            CRN_A: begin
                row      = near_row;
                col      = near_col;
                skip_c_o = (rect_i.x == '0) || (rect_i.y == '0);
            end
        endcase
        addr_c_o = AW'(TILE_W'(row) * tile_size_i + TILE_W'(col));
    end

endmodule

// File: rtl/rect_sum_reader.sv
// Rectangle pixel sum from an integral-image tile: reads up to four corners and returns D-B-C+A.
module rect_sum_reader
    import facedet_pkg::*;
#(
    parameter int unsigned DATA_W = facedet_pkg::DATA_W,
    parameter int unsigned ADDR_W = facedet_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TILE_W-1:0]   tile_size,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COORD_W-1:0]  req_x,
    input  logic [COORD_W-1:0]  req_y,
    input  logic [COORD_W-1:0]  req_w,
    input  logic [COORD_W-1:0]  req_h,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_sum,
    output logic                rsp_err
);

    localparam int unsigned EW = COORD_W + 1;

    state_e              state_q;
    rect_t               rect_q;
    logic [TILE_W-1:0]   tile_q;
    logic [2:0]          pend_q;
    logic                req_ready_q;
    logic                mem_en_q;
    logic                mem_neg_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                rd_pend_q;
    logic                rd_neg_q;
    logic [DATA_W-1:0]   acc_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_sum_q;
    logic                rsp_err_q;

    rect_t               req_rect_c;
    rect_t               gen_rect_c;
    logic [TILE_W-1:0]   gen_tile_c;
    logic [ADDR_W-1:0]   crn_addr_c [4];
    logic [3:0]          crn_skip_c;
    logic                accept_c;
    logic                req_err_c;
    logic [EW-1:0]       x_end_c;
    logic [EW-1:0]       y_end_c;
    logic [1:0]          nxt_idx_c;
    logic [2:0]          pend_clr_c;
    logic [DATA_W-1:0]   acc_upd_c;

    assign req_rect_c = '{x: req_x, y: req_y, w: req_w, h: req_h};
    assign accept_c   = req_valid && req_ready_q;

    // In IDLE the generators see the live request so the D read can issue on the accept edge.
    assign gen_rect_c = (state_q == ST_IDLE) ? req_rect_c : rect_q;
    assign gen_tile_c = (state_q == ST_IDLE) ? tile_size  : tile_q;

    assign x_end_c   = EW'(req_x) + EW'(req_w);
    assign y_end_c   = EW'(req_y) + EW'(req_h);
    assign req_err_c = (req_w == '0) || (req_h == '0) ||
                       (TILE_W'(x_end_c) > tile_size) || (TILE_W'(y_end_c) > tile_size);

    for (genvar k = 0; k < 4; k++) begin : g_corner
        rect_addr_gen #(
            .AW          (ADDR_W)
        ) u_addr_gen (
            .corner_i    (corner_e'(2'(k))),
            .rect_i      (gen_rect_c),
            .tile_size_i (gen_tile_c),
            .addr_c_o    (crn_addr_c[k]),
            .skip_c_o    (crn_skip_c[k])
        );
    end

    // pend_q bit 0/1/2 = B/C/A still to be read; pick the first in fetch order.
    always_comb begin
        nxt_idx_c  = 2'd3;
        pend_clr_c = 3'b100;
        if (pend_q[0]) begin
            nxt_idx_c  = 2'd1;
            pend_clr_c = 3'b001;
        end else if (pend_q[1]) begin
            nxt_idx_c  = 2'd2;
            pend_clr_c = 3'b010;
        end
    end

    always_comb begin
        acc_upd_c = acc_q;
        if (rd_pend_q) begin
            acc_upd_c = rd_neg_q ? (acc_q - mem_rdata) : (acc_q + mem_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rect_q      <= '0;
            tile_q      <= '0;
            pend_q      <= '0;
            req_ready_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_neg_q   <= 1'b0;
            mem_addr_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_neg_q    <= 1'b0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rd_pend_q <= mem_en_q;
            rd_neg_q  <= mem_neg_q;
            acc_q     <= acc_upd_c;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_c) begin
                        req_ready_q <= 1'b0;
                        rect_q      <= req_rect_c;
                        tile_q      <= tile_size;
                        acc_q       <= '0;
                        if (req_err_c) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_sum_q   <= '0;
                        end else begin
                            state_q    <= ST_FETCH;
                            mem_en_q   <= !crn_skip_c[0];
                            mem_addr_q <= crn_addr_c[0];
                            mem_neg_q  <= corner_negative(CRN_D);
                            pend_q     <= ~crn_skip_c[3:1];
                        end
                    end
                end
                ST_FETCH: begin
                    if (pend_q != '0) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= crn_addr_c[nxt_idx_c];
                        mem_neg_q  <= corner_negative(corner_e'(nxt_idx_c));
                        pend_q     <= pend_q & ~pend_clr_c;
                    end else begin
                        mem_en_q <= 1'b0;
                        state_q  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_sum_q   <= acc_upd_c;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rect_sum_reader.sv
// Bench for rect_sum_reader: directed table on a known tile, stall/reset sequences, random vs. reference model.
module tb_rect_sum_reader;

    typedef logic [16:0] addr4_t [4];

    typedef struct {
        int          x;
        int          y;
        int          w;
        int          h;
        int          t;
        bit          err;
        logic [31:0] sum;
        int          n;
        addr4_t      a;
        int          stall;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] tile_size;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_x, req_y, req_w, req_h;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_err;

    logic [31:0] mem [0:(1<<17)-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_waits = 0;
    vec_t        tbl [$];

    rect_sum_reader dut (
        .clk       (clk),
        .reset     (reset),
        .tile_size (tile_size),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous tile memory: data one cycle after the read strobe.
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_tile6();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                mem[r*6 + c] = 32'(255 * (r + 1) * (c + 1));
    endtask

    task automatic add_vec(input int x, y, w, h, t, input bit err, input logic [31:0] sum,
                           input int n, input int a0, a1, a2, a3, input int stall);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.t = t;
        v.err = err; v.sum = sum; v.n = n; v.stall = stall;
        v.a[0] = 17'(a0); v.a[1] = 17'(a1); v.a[2] = 17'(a2); v.a[3] = 17'(a3);
        tbl.push_back(v);
    endtask

    // Reference: rectangle-sum rule straight from the corner definitions.
    task automatic model(input int x, y, w, h, t, output bit err, output logic [31:0] sum,
                         output int n, output addr4_t a);
        int          rs [4];
        int          cs [4];
        logic [31:0] v;
        rs = '{y + h - 1, y - 1, y + h - 1, y - 1};
        cs = '{x + w - 1, x + w - 1, x - 1, x - 1};
        err = (w == 0) || (h == 0) || (x + w > t) || (y + h > t);
        sum = '0;
        n = 0;
        for (int i = 0; i < 4; i++) a[i] = '0;
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (rs[i] >= 0 && cs[i] >= 0) begin
                    a[n] = 17'(rs[i] * t + cs[i]);
                    v = mem[a[n]];
                    sum = (i == 1 || i == 2) ? sum - v : sum + v;
                    n++;
                end
            end
        end
    endtask

    task automatic run_req(input string tag, input int x, y, w, h, t, input int stall,
                           input bit exp_err, input logic [31:0] exp_sum, input int exp_n,
                           input addr4_t exp_a);
        int          waits;
        int          k;
        bit          seen;
        logic [16:0] got [$];
        waits = 0;
        k = 1;
        seen = 1'b0;
        while (!req_ready && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        last_waits = waits;
        req_x = 16'(x); req_y = 16'(y); req_w = 16'(w); req_h = 16'(h);
        tile_size = 32'(t);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!seen && k <= 30) begin
            if (mem_en) got.push_back(mem_addr);
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk({tag, " latency"}, seen ? 32'(k) : 32'hffff_ffff, exp_err ? 32'd1 : 32'(exp_n + 2));
        if (!seen) return;
        chk({tag, " sum"}, rsp_sum, exp_sum);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " reads"}, 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++)
            chk($sformatf("%s addr%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff,
                32'(exp_a[i]));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " stall sum"}, rsp_sum, exp_sum);
            chk({tag, " stall err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, " stall ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " post valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit          m_err;
        logic [31:0] m_sum;
        int          m_n;
        addr4_t      m_a;
        int          t, x, y, w, h;

        reset = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; tile_size = '0;
        fill_tile6();

        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_sum", rsp_sum, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel req_ready", 32'(req_ready), 32'd1);

        // Tile 6x6, I[r][c] = 255*(r+1)*(c+1): every pixel is 255.
        add_vec(1, 1, 2, 2, 6, 1'b0, 32'd1020, 4, 14, 2, 12, 0, 3);
        add_vec(0, 0, 6, 6, 6, 1'b0, 32'd9180, 1, 35, 0, 0, 0, 0);
        add_vec(0, 2, 3, 1, 6, 1'b0, 32'd765,  2, 14, 8, 0, 0, 0);
        add_vec(5, 0, 2, 1, 6, 1'b1, 32'd0,    0, 0, 0, 0, 0, 0);
        add_vec(5, 0, 0, 1, 6, 1'b1, 32'd0,    0, 0, 0, 0, 0, 2);
        add_vec(5, 5, 1, 1, 6, 1'b0, 32'd255,  4, 35, 29, 34, 28, 0);
        add_vec(2, 3, 1, 0, 6, 1'b1, 32'd0,    0, 0, 0, 0, 0, 0);
        add_vec(0, 4, 1, 3, 6, 1'b1, 32'd0,    0, 0, 0, 0, 0, 0);
        add_vec(3, 0, 2, 2, 6, 1'b0, 32'd1020, 2, 10, 8, 0, 0, 1);
        add_vec(0, 0, 1, 1, 0, 1'b1, 32'd0,    0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1, 6, 1'b0, 32'd255,  1, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            run_req($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].t,
                    tbl[i].stall, tbl[i].err, tbl[i].sum, tbl[i].n, tbl[i].a);
            if (i > 0) chk($sformatf("vec%0d back-to-back", i), 32'(last_waits), 32'd0);
        end

        // Reset two cycles into a four-read request: no response, bus quiet, then normal service.
        req_x = 16'd1; req_y = 16'd1; req_w = 16'd2; req_h = 16'd2; tile_size = 32'd6;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort mem_en", 32'(mem_en), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort quiet rsp_valid", 32'(rsp_valid), 32'd0);
            chk("abort quiet mem_en", 32'(mem_en), 32'd0);
        end
        run_req("after_abort", tbl[0].x, tbl[0].y, tbl[0].w, tbl[0].h, tbl[0].t, 0,
                tbl[0].err, tbl[0].sum, tbl[0].n, tbl[0].a);

        // Random tiles with random word contents, including wrap-around sums and error cases.
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        for (int i = 0; i < 40; i++) begin
            t = int'($urandom_range(1, 20));
            x = int'($urandom_range(0, t));
            w = int'($urandom_range(0, t - x + 1));
            y = int'($urandom_range(0, t));
            h = int'($urandom_range(0, t - y + 1));
            model(x, y, w, h, t, m_err, m_sum, m_n, m_a);
            run_req($sformatf("rnd%0d", i), x, y, w, h, t, int'($urandom_range(0, 2)),
                    m_err, m_sum, m_n, m_a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
